// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI write engine.
// Holds the one-hot state encoding, the position of the D/C flag in the
// incoming 9-bit word, the command/data flag values and the default timing
// parameters used by lcd_spi_write and lcd_spi_tick.
package lcd_pkg;

   // One-hot state codes, one bit per state
   localparam logic [5:0] ST_IDLE  = 6'b000001;
   localparam logic [5:0] ST_SETUP = 6'b000010;
   localparam logic [5:0] ST_SHIFT = 6'b000100;
   localparam logic [5:0] ST_HOLD  = 6'b001000;
   localparam logic [5:0] ST_DONE  = 6'b010000;
   localparam logic [5:0] ST_GAP   = 6'b100000;

   typedef enum logic [5:0] {
      IDLE  = ST_IDLE,
      SETUP = ST_SETUP,
      SHIFT = ST_SHIFT,
      HOLD  = ST_HOLD,
      DONE  = ST_DONE,
      GAP   = ST_GAP
   } lcdState_t;

   // Bit 8 of the incoming word selects command (0) or data (1)
   localparam int DC_BIT = 8;
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // Default timing: sys_clk cycles per SCLK half-period, and post-done gap
   localparam int DEF_HALF_PERIOD = 2;
   localparam int DEF_GAP_CYCLES  = 3;

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period timebase for the SPI engine.
// Counts sys_clk cycles and flags the last cycle of every HALF_PERIOD-long
// phase, so the FSM can move SCLK exactly on phase boundaries.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_restart  synchronous restart: holds the counter at zero, no tick
//   o_tick     high during the final cycle of each half-period
module lcd_spi_tick
   import lcd_pkg::*;
#(
   parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   output logic o_tick
);

   // A one-cycle half-period still needs a 1-bit counter to exist
   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] r_count;
   logic          w_atLast;

   assign w_atLast = (r_count == LAST);
   assign o_tick   = w_atLast && !i_restart;

   // Counter wraps on the last cycle of a phase, so consecutive phases
   // follow each other with no dead cycle and it never wraps mid-phase
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_restart || w_atLast) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/lcd_spi_write.sv
// Serial write engine for the LCD panel.
// Accepts one 9-bit word (bit 8 = D/C, bits 7:0 = payload) when en_write is
// high in IDLE, shifts the payload out MSB-first on a mode-0 SPI link, and
// pulses wr_done for one cycle when the byte has been sent. A short gap
// follows during which new requests are ignored.
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   en_write   level request, data valid
//   data       [8] D/C flag, [7:0] byte to send
//   wr_done    one-cycle completion pulse
//   busy       high from latch until the end of the gap
//   lcd_sclk   SPI clock, idle low
//   lcd_mosi   SPI data, MSB first
//   lcd_dc     0 = command, 1 = data
//   lcd_cs     chip select, active low
module lcd_spi_write
   import lcd_pkg::*;
#(
   parameter int HALF_PERIOD = DEF_HALF_PERIOD,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       en_write,
   input  logic [8:0] data,
   output logic       wr_done,
   output logic       busy,
   output logic       lcd_sclk,
   output logic       lcd_mosi,
   output logic       lcd_dc,
   output logic       lcd_cs
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   lcdState_t r_state, w_stateNext;
   logic [7:0]    r_shift, w_shiftNext;
   logic [2:0]    r_bitCnt, w_bitNext;
   logic [GW-1:0] r_gapCount, w_gapNext;
   logic r_sclk, w_sclkNext;
   logic r_mosi, w_mosiNext;
   logic r_dc, w_dcNext;
   logic r_cs, w_csNext;
   logic r_busy, w_busyNext;
   logic r_done, w_doneNext;
   logic w_tick;
   logic w_restart;

   // The half-period timer only runs in the SCLK-timed states; SETUP,
   // SHIFT and HOLD chain back to back so the timer free-runs across them
   assign w_restart = (r_state != SETUP) && (r_state != SHIFT) && (r_state != HOLD);

   lcd_spi_tick #(
      .HALF_PERIOD(HALF_PERIOD)
   ) uTick (
      .i_clk    (sys_clk),
      .i_rst_n  (sys_rst_n),
      .i_restart(w_restart),
      .o_tick   (w_tick)
   );

   // State and output registers; every port is driven directly by a flop
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bitCnt   <= '0;
         r_gapCount <= '0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_dc       <= 1'b0;
         r_cs       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_shift    <= w_shiftNext;
         r_bitCnt   <= w_bitNext;
         r_gapCount <= w_gapNext;
         r_sclk     <= w_sclkNext;
         r_mosi     <= w_mosiNext;
         r_dc       <= w_dcNext;
         r_cs       <= w_csNext;
         r_busy     <= w_busyNext;
         r_done     <= w_doneNext;
      end
   end

   // Next-state and next-output logic. In SHIFT, the falling SCLK tick
   // presents the next bit (the shift register keeps the current bit at
   // position 7, so the next one is at position 6); the rising tick either
   // starts the next bit or, after bit 7's low phase, moves to HOLD.
   always_comb begin
      w_stateNext = r_state;
      w_shiftNext = r_shift;
      w_bitNext   = r_bitCnt;
      w_gapNext   = r_gapCount;
      w_sclkNext  = r_sclk;
      w_mosiNext  = r_mosi;
      w_dcNext    = r_dc;
      w_csNext    = r_cs;
      w_busyNext  = r_busy;
      w_doneNext  = 1'b0;
      case (r_state)
         IDLE: begin
            w_csNext   = 1'b1;
            w_sclkNext = 1'b0;
            if (en_write) begin
               w_shiftNext = data[7:0];
               w_dcNext    = data[DC_BIT];
               w_mosiNext  = data[7];
               w_csNext    = 1'b0;
               w_busyNext  = 1'b1;
               w_bitNext   = 3'd0;
               w_stateNext = SETUP;
            end
         end
         SETUP: begin
            if (w_tick) begin
               w_sclkNext  = 1'b1;
               w_stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (w_tick) begin
               if (r_sclk) begin
                  w_sclkNext = 1'b0;
                  if (r_bitCnt != 3'd7) begin
                     w_shiftNext = {r_shift[6:0], 1'b0};
                     w_mosiNext  = r_shift[6];
                  end
               end else if (r_bitCnt == 3'd7) begin
                  w_stateNext = HOLD;
               end else begin
                  w_sclkNext = 1'b1;
                  w_bitNext  = r_bitCnt + 3'd1;
               end
            end
         end
         HOLD: begin
            if (w_tick) begin
               w_csNext    = 1'b1;
               w_doneNext  = 1'b1;
               w_stateNext = DONE;
            end
         end
         DONE: begin
            w_gapNext   = '0;
            w_stateNext = GAP;
         end
         GAP: begin
            if (r_gapCount == GAP_LAST) begin
               w_gapNext   = '0;
               w_busyNext  = 1'b0;
               w_stateNext = IDLE;
            end else begin
               w_gapNext = r_gapCount + GW'(1);
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_sclkNext  = 1'b0;
            w_csNext    = 1'b1;
            w_busyNext  = 1'b0;
         end
      endcase
   end

   assign wr_done  = r_done;
   assign busy     = r_busy;
   assign lcd_sclk = r_sclk;
   assign lcd_mosi = r_mosi;
   assign lcd_dc   = r_dc;
   assign lcd_cs   = r_cs;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Testbench for lcd_spi_write with default timing (H = 2, gap = 3).
// A negedge monitor reassembles each serialised byte from MOSI on SCLK
// rising edges and, on every wr_done, compares it with the next entry of a
// scoreboard queue filled when the bench drives a write.
module tb_lcd_spi_write;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       en_write;
   logic [8:0] data;
   logic       wr_done;
   logic       busy;
   logic       lcd_sclk;
   logic       lcd_mosi;
   logic       lcd_dc;
   logic       lcd_cs;

   // Edges from latch to wr_done (high in cycle 37), and latch-to-latch
   localparam int DONE_LATENCY = 36;
   localparam int B2B_SPACING  = 41;

   typedef struct {
      logic [8:0] din;
      logic       expDc;
      logic [7:0] expByte;
   } vec_t;

   vec_t vecs[5];

   logic [8:0] sbQueue[$];

   int checkCount = 0;
   int errCount   = 0;
   int cycleCnt   = 0;
   int latchCycle = 0;
   int prevLatchCycle = 0;
   int latchCount = 0;
   int doneCount  = 0;
   int capEdges   = 0;
   int pushCount  = 0;
   int abortCount = 0;
   logic [7:0] capBits;
   logic prevSclk, prevDone, prevBusy;
   logic [8:0] expWord;

   lcd_spi_write #(
      .HALF_PERIOD(2),
      .GAP_CYCLES (3)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en_write (en_write),
      .data     (data),
      .wr_done  (wr_done),
      .busy     (busy),
      .lcd_sclk (lcd_sclk),
      .lcd_mosi (lcd_mosi),
      .lcd_dc   (lcd_dc),
      .lcd_cs   (lcd_cs)
   );

   // 100 MHz clock
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Free-running edge counter used to time latch and done events
   always @(posedge sys_clk) cycleCnt++;

   // Global time bound so a stuck design cannot hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Step to just after the next falling edge, after the monitor has run
   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".wr_done"}, wr_done, 0);
      checkOutput({tag, ".busy"}, busy, 0);
      checkOutput({tag, ".sclk"}, lcd_sclk, 0);
      checkOutput({tag, ".mosi"}, lcd_mosi, 0);
      checkOutput({tag, ".dc"}, lcd_dc, 0);
      checkOutput({tag, ".cs"}, lcd_cs, 1);
   endtask

   // Push the expected word, present one word for a single edge and check
   // the signals that must change on the latch edge itself
   task automatic applyStimulus(input logic [8:0] din, input logic [8:0] expW);
      sbQueue.push_back(expW);
      pushCount++;
      data     = din;
      en_write = 1'b1;
      tick();
      en_write = 1'b0;
      checkOutput("busyAtLatch", busy, 1);
      checkOutput("csAtLatch", lcd_cs, 0);
      checkOutput("dcAtLatch", lcd_dc, expW[8]);
      checkOutput("mosiAtLatch", lcd_mosi, expW[7]);
   endtask

   task automatic waitForDone(input int limit);
      for (int n = 0; n < limit && !wr_done; n++) tick();
      checkOutput("doneSeen", wr_done, 1);
   endtask

   task automatic waitForIdle(input int limit);
      for (int n = 0; n < limit && busy; n++) tick();
      checkOutput("idleSeen", busy, 0);
   endtask

   // Monitor: latch detection, MOSI capture on SCLK rise, done checks
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         capBits  = '0;
         capEdges = 0;
         prevSclk = 1'b0;
         prevDone = 1'b0;
         prevBusy = 1'b0;
      end else begin
         if (busy && !prevBusy) begin
            prevLatchCycle = latchCycle;
            latchCycle     = cycleCnt;
            latchCount++;
            capBits  = '0;
            capEdges = 0;
         end
         if (lcd_sclk && !prevSclk) begin
            capBits = {capBits[6:0], lcd_mosi};
            capEdges++;
         end
         if (prevDone) checkOutput("doneWidth", wr_done, 0);
         if (wr_done && !prevDone) begin
            doneCount++;
            checkOutput("csAtDone", lcd_cs, 1);
            checkOutput("sclkEdges", capEdges, 8);
            checkOutput("latency", cycleCnt - latchCycle, DONE_LATENCY);
            checkOutput("sbNotEmpty", sbQueue.size() > 0, 1);
            if (sbQueue.size() > 0) begin
               expWord = sbQueue.pop_front();
               checkOutput("word", {lcd_dc, capBits}, expWord);
            end
         end
         prevSclk = lcd_sclk;
         prevDone = wr_done;
         prevBusy = busy;
      end
   end

   initial begin
      int base;
      int doneBefore;

      vecs[0] = '{din: 9'h02A, expDc: 1'b0, expByte: 8'h2A};
      vecs[1] = '{din: 9'h1EF, expDc: 1'b1, expByte: 8'hEF};
      vecs[2] = '{din: 9'h155, expDc: 1'b1, expByte: 8'h55};
      vecs[3] = '{din: 9'h0FF, expDc: 1'b0, expByte: 8'hFF};
      vecs[4] = '{din: 9'h180, expDc: 1'b1, expByte: 8'h80};

      sys_rst_n = 1'b0;
      en_write  = 1'b0;
      data      = '0;
      repeat (3) tick();
      checkResetValues("reset");
      sys_rst_n = 1'b1;
      repeat (2) tick();

      // Single transfers from the vector table
      $display("[TB] single transfers");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].din, {vecs[i].expDc, vecs[i].expByte});
         waitForDone(60);
         waitForIdle(20);
         repeat (2) tick();
      end

      // Back-to-back: en_write held, data swapped three cycles after done
      $display("[TB] back-to-back");
      base = latchCount;
      sbQueue.push_back(9'h0C3);
      pushCount++;
      data     = 9'h0C3;
      en_write = 1'b1;
      waitForDone(60);
      repeat (3) tick();
      sbQueue.push_back(9'h100);
      pushCount++;
      data = 9'h100;
      for (int n = 0; n < 20 && latchCount < base + 2; n++) tick();
      en_write = 1'b0;
      checkOutput("b2bLatches", latchCount, base + 2);
      checkOutput("b2bSpacing", latchCycle - prevLatchCycle, B2B_SPACING);
      waitForDone(60);
      waitForIdle(20);
      repeat (4) tick();
      checkOutput("b2bNoRepeat", latchCount, base + 2);

      // Data toggling during the transfer must not affect the sent byte
      $display("[TB] data stability");
      applyStimulus(9'h05A, 9'h05A);
      for (int n = 0; n < 60 && !wr_done; n++) begin
         data = 9'($urandom);
         tick();
      end
      checkOutput("doneSeen", wr_done, 1);
      waitForIdle(20);
      repeat (2) tick();

      // en_write raised only during the gap cycles is ignored
      $display("[TB] ignore during gap");
      applyStimulus(9'h133, 9'h133);
      waitForDone(60);
      base = latchCount;
      tick();
      en_write = 1'b1;
      repeat (3) tick();
      en_write = 1'b0;
      checkOutput("busyAfterGap", busy, 0);
      repeat (6) tick();
      checkOutput("gapNoLatch", latchCount, base);
      checkOutput("csAfterGap", lcd_cs, 1);

      // Reset in the middle of bit 4 aborts without a done pulse
      $display("[TB] abort on reset");
      applyStimulus(9'h0F0, 9'h0F0);
      for (int n = 0; n < 40 && capEdges < 5; n++) tick();
      checkOutput("reachedBit4", capEdges, 5);
      doneBefore = doneCount;
      sys_rst_n = 1'b0;
      #1;
      checkResetValues("abort");
      sbQueue.delete();
      abortCount++;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      repeat (3) tick();
      checkOutput("abortNoDone", doneCount, doneBefore);
      applyStimulus(9'h0A5, 9'h0A5);
      waitForDone(60);
      waitForIdle(20);
      repeat (2) tick();

      checkOutput("sbEmpty", sbQueue.size(), 0);
      checkOutput("doneCount", doneCount, pushCount - abortCount);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/lcd_spi_write.md
Name: lcd_spi_write

Overview:
Serial write engine on the consumer side of the LCD display-control handshake. It accepts one 9-bit word from a frame/row generator, where bit 8 is D/C (0 = command, 1 = data) and bits 7:0 are the payload. It serialises the payload MSB-first over a 4-wire SPI link (mode 0), drives the panel's DC and CS lines, and returns a one-cycle wr_done pulse. Upstream generators present a word with a level en_write and advance on wr_done. They need about 3 cycles after wr_done to present the next word.

Parameters:
HALF_PERIOD, 2, sys_clk cycles per SCLK half-period (H); legal range >= 1
GAP_CYCLES, 3, post-done cycles during which en_write is ignored; legal range >= 1

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset, asynchronous, active-low
en_write  input  1  level request: data is valid and a write is wanted
data  input  9  [8] = D/C flag, [7:0] = byte to send
wr_done  output  1  one-cycle pulse when the byte is fully sent
busy  output  1  high from latch until the end of the gap
lcd_sclk  output  1  SPI clock, idle low
lcd_mosi  output  1  SPI data, MSB first
lcd_dc  output  1  0 = command, 1 = data
lcd_cs  output  1  chip select, active low

Behaviour:
- Single clock domain sys_clk. Reset is asynchronous, active-low (sys_rst_n). All state is registered; every output comes straight from a flop.
- Reset values: state = IDLE, wr_done = 0, busy = 0, lcd_sclk = 0, lcd_mosi = 0, lcd_dc = 0, lcd_cs = 1, all counters = 0. Reset asserted mid-transfer aborts immediately to these values; no wr_done is issued for the aborted byte.
- States, one-hot: IDLE, SETUP, SHIFT, HOLD, DONE, GAP.
- IDLE: lcd_cs = 1, lcd_sclk = 0. If en_write = 1 at a clock edge (call it edge 0):
  - latch data[7:0] into the shift register and data[8] into lcd_dc;
  - set lcd_mosi = data[7] and lcd_cs = 0;
  - set busy = 1 and go to SETUP.
  - Later changes on data or en_write have no effect until the next IDLE.
- SETUP: H cycles, lcd_sclk = 0, MOSI stable. On exit, lcd_sclk = 1 and go to SHIFT.
- SHIFT: 8 bits, each H cycles high then H cycles low (16H cycles total).
  - At each high-to-low transition, lcd_sclk = 0 and, if bits remain, lcd_mosi = next bit.
  - Bit counter is 3 bits.
  - After the low phase of bit 7, go to HOLD with lcd_sclk = 0.
- HOLD: H cycles, CS still low. On exit, lcd_cs = 1, wr_done = 1, go to DONE.
- DONE: exactly 1 cycle, wr_done = 1. Then wr_done = 0, go to GAP.
- GAP: GAP_CYCLES cycles, en_write ignored, CS high. On exit, busy = 0, go to IDLE.
- Latency: wr_done is high during cycle 18H+1 counted from edge 0; with H = 2 that is cycle 37. Minimum spacing between consecutive latch edges is 18H+2+GAP_CYCLES; with defaults, 41.
- Exactly 8 rising SCLK edges per byte, and exactly one wr_done per latched byte.
- en_write held continuously high yields back-to-back transfers separated by the gap.
- The phase counter is sized as clog2(HALF_PERIOD) bits and never wraps mid-phase.

Decomposition:
- Shared package lcd_pkg holds:
  - state one-hot localparams (IDLE..GAP);
  - D/C bit index (8);
  - CMD/DATA flag constants;
  - default HALF_PERIOD and GAP_CYCLES.
- One natural sub-module, lcd_spi_tick: phase counter that emits a tick after HALF_PERIOD cycles, with a synchronous restart input. The FSM and shift register stay in lcd_spi_write.

Test Plan:
- Send a command: reset, then en_write = 1 with data = 9'h02A for one cycle → lcd_dc = 0 and lcd_cs low. MOSI sampled on the 8 SCLK rising edges reads 0,0,1,0,1,0,1,0. wr_done pulses once, 37 cycles after the latch edge. lcd_cs returns to 1 in the same cycle.
- Send a data byte: data = 9'h1EF → lcd_dc = 1. MOSI bits read 1,1,1,0,1,1,1,1 and there are exactly 8 rising SCLK edges.
- Back-to-back: en_write held high and data changed to 9'h100 three cycles after wr_done → second latch occurs 41 cycles after the first. The second transfer sends 8'h00 with dc = 1, and nothing is sent twice.
- Data stability: data toggles randomly while in SHIFT → the serialised byte equals the value latched at edge 0.
- Ignore during gap: en_write pulsed only during the GAP cycles → no new transfer starts and busy returns to 0.
- Abort on reset: sys_rst_n pulsed low mid-SHIFT (bit 4) → outputs return to reset values asynchronously with no wr_done. A new write afterwards completes normally in 37 cycles.
